branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// ============================================================================
// branch_predictor : direct-mapped BTB with 2-bit counters, mispredict stats
// Revision 1.0
// ============================================================================
`default_nettype none

module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_f,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [4:0]  upd_brop,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [15:0] br_cnt,
  output logic [15:0] miss_cnt
);

  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic             jmp_q    [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_d [ENTRIES];
  logic             jmp_d    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];

  logic        mispredict_q, mispredict_d;
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_qual;
  logic             u_miss;

  // Only the index/tag bits and BrOp class bits carry meaning here.
  logic unused_bits;
  assign unused_bits = &{1'b0, upd_pc[1:0], upd_brop[2:0]};

  // Fetch-side lookup reads registered state only, so a same-cycle update
  // to the same index is not bypassed.
  always_comb begin
    f_idx       = pc_f[IDX_W+1:2];
    f_tag       = pc_f[31:IDX_W+2];
    f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = f_hit && (jmp_q[f_idx] || ctr_q[f_idx][1]);
    pred_target = f_hit ? target_q[f_idx] : (pc_f + 32'd4);
  end

  always_comb begin
    u_idx  = upd_pc[IDX_W+1:2];
    u_tag  = upd_pc[31:IDX_W+2];
    u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_qual = upd_valid && (upd_brop[4:3] != 2'b00);
    u_miss = (upd_pred_taken != upd_taken) ||
             (upd_taken && (upd_pred_target != upd_target));
  end

  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    jmp_d        = jmp_q;
    ctr_d        = ctr_q;
    mispredict_d = 1'b0;
    br_cnt_d     = br_cnt_q;
    miss_cnt_d   = miss_cnt_q;

    if (u_qual) begin
      mispredict_d = u_miss;
      if (br_cnt_q != 16'hFFFF) begin
        br_cnt_d = br_cnt_q + 16'd1;
      end
      if (u_miss && (miss_cnt_q != 16'hFFFF)) begin
        miss_cnt_d = miss_cnt_q + 16'd1;
      end

      if (u_hit) begin
        if (upd_taken) begin
          ctr_d[u_idx]    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : (ctr_q[u_idx] + 2'd1);
          target_d[u_idx] = upd_target;
          jmp_d[u_idx]    = upd_brop[4];
        end else begin
          ctr_d[u_idx]    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : (ctr_q[u_idx] - 2'd1);
        end
      end else if (upd_taken) begin
        // Allocation evicts whatever occupied the slot, starting weakly taken.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        jmp_d[u_idx]    = upd_brop[4];
        ctr_d[u_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'd0;
        jmp_q[i]    <= 1'b0;
        ctr_q[i]    <= 2'b01;
      end
      mispredict_q <= 1'b0;
      br_cnt_q     <= 16'd0;
      miss_cnt_q   <= 16'd0;
    end else begin
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      target_q     <= target_d;
      jmp_q        <= jmp_d;
      ctr_q        <= ctr_d;
      mispredict_q <= mispredict_d;
      br_cnt_q     <= br_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign mispredict = mispredict_q;
  assign br_cnt     = br_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

`default_nettype wire
